div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 32 +++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared ALU/divider definitions: operation codes, divider state encodings,
// iteration count and the latched-operand payload.
package div_unit_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned DIV_ITERS = 32;

  // ALU operation codes, same encoding the ALU decoder drives
  localparam logic [OP_W-1:0] ALU_DIV  = 6'h1a;
  localparam logic [OP_W-1:0] ALU_DIVU = 6'h1b;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic              sign_mode;
    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
  } div_op_t;

  // Conditional two's-complement negate; doubles as absolute value on entry
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                 input logic              neg);
    return neg ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider handshake: operation request in, stall and HI/LO result out.
interface div_unit_if;

  logic [div_unit_pkg::OP_W-1:0]   alu_control;
  logic                            valid;
  logic                            flush;
  logic [div_unit_pkg::DATA_W-1:0] a;
  logic [div_unit_pkg::DATA_W-1:0] b;
  logic                            stall;
  logic                            result_valid;
  logic [div_unit_pkg::DATA_W-1:0] hi_out;
  logic [div_unit_pkg::DATA_W-1:0] lo_out;

  modport master (
    output alu_control, valid, flush, a, b,
    input  stall, result_valid, hi_out, lo_out
  );

  modport slave (
    input  alu_control, valid, flush, a, b,
    output stall, result_valid, hi_out, lo_out
  );

endinterface

// File: rtl/div_unit.sv
// Iterative 32-cycle radix-2 restoring divider for DIV/DIVU with sign
// pre/post-processing; quotient on lo_out, remainder on hi_out.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                stall;
  logic                is_div;
  logic                start;
  logic                finish;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] sr;
  logic [2*DATA_W-1:0] sr_step;
  logic [DATA_W:0]     rem_trial;
  logic [DATA_W-1:0]   rem_diff;
  logic                rem_ge;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
  div_op_t             op;
  div_op_t             op_new;
  logic                result_valid_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  // Request decode and operand capture values
  always_comb begin
    is_div = (bus.alu_control == ALU_DIV) || (bus.alu_control == ALU_DIVU);
    start  = bus.valid & ~bus.flush & (state == S_IDLE) & is_div;
    finish = (state == S_CALC) & ~bus.flush & (cnt == CNT_W'(DIV_ITERS - 1));

    op_new.sign_mode = (bus.alu_control == ALU_DIV);
    op_new.sign_a    = op_new.sign_mode & bus.a[DATA_W-1];
    op_new.sign_b    = op_new.sign_mode & bus.b[DATA_W-1];
    op_new.mag_a     = cond_neg(bus.a, op_new.sign_a);
    op_new.mag_b     = cond_neg(bus.b, op_new.sign_b);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state; flush in CALC abandons the operation without a result
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        stall = start;
        if (start) state_nxt = S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (bus.flush)                              state_nxt = S_IDLE;
        else if (cnt == CNT_W'(DIV_ITERS - 1))      state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step; the partial remainder stays below the divisor, so
  // the shifted value fits in 33 bits and the difference fits in 32.
  always_comb begin
    rem_trial = sr[2*DATA_W-1:DATA_W-1];
    rem_ge    = (rem_trial >= {1'b0, op.mag_b});
    rem_diff  = rem_trial[DATA_W-1:0] - op.mag_b;
    if (rem_ge) sr_step = {rem_diff, sr[DATA_W-2:0], 1'b1};
    else        sr_step = {rem_trial[DATA_W-1:0], sr[DATA_W-2:0], 1'b0};

    quot_fix = cond_neg(sr_step[DATA_W-1:0], op.sign_a ^ op.sign_b);
    rem_fix  = cond_neg(sr_step[2*DATA_W-1:DATA_W], op.sign_a);
    // Divide-by-zero: all-ones quotient; remainder already reconstructs a
    if (op.mag_b == '0) quot_fix = '1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op  <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      op  <= op_new;
      sr  <= {DATA_W'(0), op_new.mag_a};
      cnt <= '0;
    end else if (state == S_CALC) begin
      sr  <= sr_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers update only on the final step so a flush leaves them intact
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_valid_q <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
    end else begin
      result_valid_q <= finish;
      if (finish) begin
        hi_q <= rem_fix;
        lo_q <= quot_fix;
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.result_valid = result_valid_q;
  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized
// DIV/DIVU traffic checked against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_unit_if bus ();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  // Reference: plain integer division, with the two architected special cases
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(x) / $signed(y));
        r = 32'($signed(x) % $signed(y));
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every result_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result_valid=1 hi=%h lo=%h expected none (cycle %0d)",
                 bus.hi_out, bus.lo_out, cyc);
      end else begin
        e = sb_q.pop_front();
        check("hi_out", bus.hi_out, e.hi);
        check("lo_out", bus.lo_out, e.lo);
        check("latency", 32'(cyc), 32'(e.due));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  // Issue one divide at posedge+1; flush_at >= 1 kills it in that cycle
  task automatic run_op(input logic [5:0] code, input logic [31:0] ea, input logic [31:0] eb,
                        input int flush_at);
    exp_t        e;
    logic [63:0] res;
    bus.alu_control = code;
    bus.a           = ea;
    bus.b           = eb;
    bus.valid       = 1'b1;
    bus.flush       = 1'b0;
    if (flush_at < 0) begin
      res   = ref_div(code == ALU_DIV, ea, eb);
      e.hi  = res[63:32];
      e.lo  = res[31:0];
      e.due = cyc + 33;
      sb_q.push_back(e);
    end
    for (int c = 0; c <= 33; c++) begin
      if (c == flush_at) bus.flush = 1'b1;
      @(negedge clk);
      check("stall", {31'd0, bus.stall}, {31'd0, (c <= 32) ? 1'b1 : 1'b0});
      if (c == 1) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (c == flush_at) begin
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
  endtask

  task automatic check_after_kill(input string tag);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    check({tag, "_rv"}, {31'd0, bus.result_valid}, 32'd0);
    check({tag, "_hi"}, bus.hi_out, last_hi);
    check({tag, "_lo"}, bus.lo_out, last_lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] code;
    bus.alu_control = '0;
    bus.valid       = 1'b0;
    bus.flush       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;

    @(negedge clk);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_rv", {31'd0, bus.result_valid}, 32'd0);
    check("rst_hi", bus.hi_out, 32'd0);
    check("rst_lo", bus.lo_out, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_op(ALU_DIVU, 32'd100, 32'd7, -1);
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(ALU_DIVU, 32'd5, 32'd0, -1);
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd0, -1);
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, -1);

    run_op(ALU_DIVU, 32'd9, 32'd3, 10);
    check_after_kill("flush10");
    run_op(ALU_DIVU, 32'd8, 32'd2, -1);

    run_op(ALU_DIV, 32'hDEAD_BEEF, 32'd13, 32);
    check_after_kill("flush32");

    // Non-divide codes never start the unit
    bus.alu_control = 6'h20;
    bus.a           = 32'd50;
    bus.b           = 32'd5;
    bus.valid       = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("nondiv_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;

    // Reset in the middle of CALC aborts with no result
    bus.alu_control = ALU_DIVU;
    bus.a           = 32'd1000;
    bus.b           = 32'd3;
    bus.valid       = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    resetn    = 1'b0;
    bus.valid = 1'b0;
    #1;
    last_hi = '0;
    last_lo = '0;
    check_after_kill("reset15");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      code = ($urandom_range(0, 1) == 0) ? ALU_DIV : ALU_DIVU;
      run_op(code, pick_operand(), pick_operand(), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
